// File: rtl/mem_access_stage.sv
// MEM stage: drives a req/ack data-memory transaction from the EX/MEM
// controls, stalls upstream while it is in flight and holds the MEM/WB
// register. Flags misaligned accesses and bus timeouts (both sticky).
// Ports:
//   clock, reset (async, active-low)
//   EX/MEM in : memRead, memWrite, memToReg, regWrite, rd, ALUin, writeDataIn
//   bus       : busReq, busWe, busAddr, busWData out; busRData, busAck in
//   status    : stall, alignError, busError
//   MEM/WB out: memToRegRegister, regWriteRegister, readDataRegister,
//               ALURegister, rdRegister
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [4:0]        rd,
    input  logic [31:0]       ALUin,
    input  logic [31:0]       writeDataIn,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [31:0]       busWData,
    input  logic [31:0]       busRData,
    input  logic              busAck,
    output logic              stall,
    output logic              alignError,
    output logic              busError,
    output logic              memToRegRegister,
    output logic              regWriteRegister,
    output logic [31:0]       readDataRegister,
    output logic [31:0]       ALURegister,
    output logic [4:0]        rdRegister
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        access;
    logic        misaligned;
    logic        timeout;
    logic        mw_rw;
    logic [31:0] mw_rdata;

    assign access     = memRead | memWrite;
    assign misaligned = access & (ALUin[1:0] != 2'b00);
    assign busReq     = (state == WAIT_ACK);

    // Ack has priority over timeout, so timeout requires busAck=0.
    assign timeout = (state == WAIT_ACK) & ~busAck &
                     (cnt == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mw_rw     = regWrite;
        mw_rdata  = '0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    mw_rw = 1'b0;
                end else if (access) begin
                    stall     = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (busAck) begin
                    state_nxt = IDLE;
                    if (!memWrite) mw_rdata = busRData;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    mw_rw     = 1'b0;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            busWe            <= 1'b0;
            busAddr          <= '0;
            busWData         <= '0;
            alignError       <= 1'b0;
            busError         <= 1'b0;
            memToRegRegister <= 1'b0;
            regWriteRegister <= 1'b0;
            readDataRegister <= '0;
            ALURegister      <= '0;
            rdRegister       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == WAIT_ACK) begin
                cnt      <= '0;
                busAddr  <= ADDR_W'({ALUin[31:2], 2'b00});
                busWData <= writeDataIn;
                busWe    <= memWrite;
            end else if (state == WAIT_ACK && stall) begin
                cnt <= cnt + 16'd1;
            end
            if (state == IDLE && misaligned) alignError <= 1'b1;
            if (timeout) busError <= 1'b1;
            // A stalled edge loads a bubble so write-back never repeats.
            if (stall) begin
                memToRegRegister <= 1'b0;
                regWriteRegister <= 1'b0;
                readDataRegister <= '0;
                ALURegister      <= '0;
                rdRegister       <= '0;
            end else begin
                memToRegRegister <= memToReg & ~(memRead & memWrite);
                regWriteRegister <= mw_rw;
                readDataRegister <= mw_rdata;
                ALURegister      <= ALUin;
                rdRegister       <= rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level model,
// per-cycle compare process, directed cases plus randomized traffic.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        memRead, memWrite, memToReg, regWrite;
    logic [4:0]  rd;
    logic [31:0] ALUin, writeDataIn;
    logic        busReq, busWe, busAck;
    logic [31:0] busAddr, busWData, busRData;
    logic        stall, alignError, busError;
    logic        memToRegRegister, regWriteRegister;
    logic [31:0] readDataRegister, ALURegister;
    logic [4:0]  rdRegister;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    logic        e_stall, e_busReq, e_busWe, e_alignErr, e_busErr;
    logic        e_m2r, e_rw, e_bubble;
    logic [31:0] e_busAddr, e_busWData, e_rdata, e_alu;
    logic [4:0]  e_rd;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .rd(rd), .ALUin(ALUin),
        .writeDataIn(writeDataIn),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .busRData(busRData), .busAck(busAck),
        .stall(stall), .alignError(alignError), .busError(busError),
        .memToRegRegister(memToRegRegister),
        .regWriteRegister(regWriteRegister),
        .readDataRegister(readDataRegister),
        .ALURegister(ALURegister), .rdRegister(rdRegister)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("busReq", 32'(busReq), 32'(e_busReq));
            chk("busWe", 32'(busWe), 32'(e_busWe));
            chk("busAddr", busAddr, e_busAddr);
            chk("busWData", busWData, e_busWData);
            chk("alignError", 32'(alignError), 32'(e_alignErr));
            chk("busError", 32'(busError), 32'(e_busErr));
            chk("memToRegReg", 32'(memToRegRegister), 32'(e_m2r));
            chk("regWriteReg", 32'(regWriteRegister), 32'(e_rw));
            chk("rdReg", 32'(rdRegister), 32'(e_rd));
            if (!e_bubble) begin
                chk("ALUReg", ALURegister, e_alu);
                chk("readDataReg", readDataRegister, e_rdata);
            end
        end
    end

    task automatic model_zero();
        e_stall = 0; e_busReq = 0; e_busWe = 0; e_busAddr = 0;
        e_busWData = 0; e_alignErr = 0; e_busErr = 0;
        e_m2r = 0; e_rw = 0; e_rd = 0; e_rdata = 0; e_alu = 0;
        e_bubble = 0;
    endtask

    task automatic inputs_zero();
        memRead = 0; memWrite = 0; memToReg = 0; regWrite = 0;
        rd = 0; ALUin = 0; writeDataIn = 0; busAck = 0; busRData = 0;
    endtask

    task automatic step_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        e_rw = 0; e_m2r = 0; e_rd = 0; e_bubble = 1;
    endtask

    task automatic cap(input logic rwv, input logic [31:0] rdat);
        e_m2r = memToReg & ~(memRead & memWrite);
        e_rw = rwv; e_rd = rd; e_alu = ALUin; e_rdata = rdat;
        e_bubble = 0;
    endtask

    // k = WAIT_ACK cycle (1-based) carrying busAck; k outside 1..T
    // means no ack and the access times out.
    task automatic op(input logic mr, input logic mw, input logic m2r,
                      input logic rw, input logic [4:0] rdv,
                      input logic [31:0] alu, input logic [31:0] wd,
                      input int k, input logic [31:0] rdat,
                      output int ns, output int nq);
        logic acc, mis;
        memRead = mr; memWrite = mw; memToReg = m2r; regWrite = rw;
        rd = rdv; ALUin = alu; writeDataIn = wd;
        busAck = 1'($urandom_range(0, 1));
        busRData = $urandom;
        acc = mr | mw;
        mis = acc && (alu[1:0] != 2'b00);
        ns = 0;
        nq = 0;
        if (!acc || mis) begin
            e_stall = 0; e_busReq = 0;
            step_edge();
            if (mis) e_alignErr = 1;
            cap(rw & ~mis, 32'h0);
        end else begin
            e_stall = 1; e_busReq = 0; ns = 1;
            step_edge();
            bubble();
            e_busAddr = {alu[31:2], 2'b00};
            e_busWData = wd;
            e_busWe = mw;
            e_busReq = 1;
            for (int j = 1; j <= T; j++) begin
                nq = j;
                busAck = (j == k);
                busRData = (j == k) ? rdat : $urandom;
                e_stall = !(j == k || j == T);
                if (e_stall) ns++;
                step_edge();
                if (j == k) begin
                    cap(rw, mw ? 32'h0 : rdat);
                    break;
                end
                if (j == T) begin
                    e_busErr = 1;
                    cap(1'b0, 32'h0);
                    break;
                end
                bubble();
            end
            e_busReq = 0;
        end
    endtask

    task automatic do_reset();
        reset = 0;
        inputs_zero();
        model_zero();
        #1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
    endtask

    initial begin
        int ns, nq, kk, ty;
        logic [31:0] a;
        reset = 0;
        inputs_zero();
        model_zero();
        #2;
        chk("rst_busReq", 32'(busReq), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rw", 32'(regWriteRegister), 32'h0);
        chk("rst_rdata", readDataRegister, 32'h0);
        chk("rst_busAddr", busAddr, 32'h0);
        chk("rst_align", 32'(alignError), 32'h0);
        chk("rst_buserr", 32'(busError), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        check_en = 1;

        op(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, ns, nq);
        chk("alu_rw", 32'(regWriteRegister), 32'h1);
        chk("alu_rd", 32'(rdRegister), 32'h5);
        chk("alu_val", ALURegister, 32'h1234);
        chk("alu_nstall", ns, 0);

        op(1, 0, 1, 1, 7, 32'h100, 0, 4, 32'hDEADBEEF, ns, nq);
        chk("ld_nstall", ns, 4);
        chk("ld_addr", busAddr, 32'h100);
        chk("ld_we", 32'(busWe), 32'h0);
        chk("ld_rdata", readDataRegister, 32'hDEADBEEF);
        chk("ld_rw", 32'(regWriteRegister), 32'h1);

        op(0, 1, 0, 0, 0, 32'h204, 32'hCAFE0001, 1, 0, ns, nq);
        chk("st_nstall", ns, 1);
        chk("st_we", 32'(busWe), 32'h1);
        chk("st_wdata", busWData, 32'hCAFE0001);
        chk("st_rdata", readDataRegister, 32'h0);

        op(1, 0, 1, 1, 9, 32'h400, 0, 0, 0, ns, nq);
        chk("to_nreq", nq, 4);
        chk("to_buserr", 32'(busError), 32'h1);
        chk("to_rw", 32'(regWriteRegister), 32'h0);

        // Reset asserted while waiting for ack.
        memRead = 1; ALUin = 32'h300; rd = 3; regWrite = 1; busAck = 0;
        e_stall = 1; e_busReq = 0;
        step_edge();
        bubble();
        e_busAddr = 32'h300; e_busWData = writeDataIn; e_busWe = 0;
        e_busReq = 1;
        step_edge();
        chk("mid_busReq_on", 32'(busReq), 32'h1);
        #1;
        check_en = 0;
        reset = 0;
        #1;
        chk("mid_busReq_off", 32'(busReq), 32'h0);
        chk("mid_rw", 32'(regWriteRegister), 32'h0);
        check_en = 1;
        do_reset();

        op(1, 0, 1, 1, 4, 32'h500, 0, 4, 32'h0BADF00D, ns, nq);
        chk("ack4_buserr", 32'(busError), 32'h0);
        chk("ack4_rdata", readDataRegister, 32'h0BADF00D);
        chk("ack4_rw", 32'(regWriteRegister), 32'h1);

        op(1, 0, 1, 1, 6, 32'h102, 0, 1, 0, ns, nq);
        chk("mis_align", 32'(alignError), 32'h1);
        chk("mis_rw", 32'(regWriteRegister), 32'h0);
        chk("mis_nstall", ns, 0);
        op(0, 0, 0, 1, 8, 32'h77, 0, 0, 0, ns, nq);
        chk("mis_sticky", 32'(alignError), 32'h1);

        for (int i = 0; i < 300; i++) begin
            ty = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
            kk = $urandom_range(1, 6);
            op(ty == 1 || ty == 3, ty == 2 || ty == 3,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom), a, $urandom, kk, $urandom, ns, nq);
        end

        inputs_zero();
        e_stall = 0;
        step_edge();
        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Turns the EX/MEM load/store controls into a req/ack transaction on the data-memory bus. While the access is in flight it stalls the upstream pipeline.
- Contains the MEM/WB register that feeds write-back.
- Covers alignment checks, bus timeout and bubble insertion during stalls.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_ACK without busAck before the access is aborted (1..65535)
ADDR_W, 32, bus address width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
memRead  in  1  load request (from EX/MEM)
memWrite  in  1  store request (from EX/MEM)
memToReg  in  1  write-back source select (from EX/MEM)
regWrite  in  1  register-file write enable (from EX/MEM)
rd  in  5  destination register (from EX/MEM)
ALUin  in  32  ALU result / effective address (from EX/MEM)
writeDataIn  in  32  store data (from EX/MEM)
busReq  out  1  bus request
busWe  out  1  1 = write, 0 = read
busAddr  out  ADDR_W  word-aligned byte address
busWData  out  32  store data
busRData  in  32  load data, valid when busAck=1
busAck  in  1  one-cycle completion pulse
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
alignError  out  1  sticky misaligned-access flag
busError  out  1  sticky timeout flag
memToRegRegister  out  1  MEM/WB write-back select
regWriteRegister  out  1  MEM/WB write enable
readDataRegister  out  32  MEM/WB load data
ALURegister  out  32  MEM/WB ALU result
rdRegister  out  5  MEM/WB destination

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs 0; state IDLE; timeout counter 0; busReq=0.
  - Reset taking effect mid-transaction abandons the access; no write-back.
- Access = memRead|memWrite. If both are 1, the access is a store and memToReg is forced 0 in MEM/WB.
- Misaligned: access with ALUin[1:0]!=0.
  - No bus cycle; alignError set (sticky until reset).
  - Completes in 1 cycle like a non-memory op, with regWrite forced 0.
- State IDLE:
  - No access, or misaligned access: stall=0. MEM/WB captures inputs at the edge; readDataRegister captures 0.
  - Aligned access: stall=1 combinationally in this cycle. At the edge, latch busAddr={ALUin[31:2],2'b00}, busWData=writeDataIn, busWe=memWrite; clear the counter; go to WAIT_ACK.
- State WAIT_ACK:
  - busReq=1. busAddr, busWData and busWe are held stable.
  - busAck=0: stall=1; counter increments.
  - busAck=1: stall=0. At the edge, MEM/WB captures the controls and ALUin; readDataRegister=busRData for loads, 0 for stores. Go to IDLE; busReq drops that edge.
  - Counter reaches TIMEOUT_CYCLES-1 with busAck=0: stall=0. At the edge, busError set (sticky); MEM/WB captures with regWrite forced 0 and readData=0; go to IDLE.
  - busAck and timeout in the same cycle: ack wins.
- Bubble rule: on every edge where stall=1, MEM/WB loads a bubble (regWriteRegister=0, memToRegRegister=0, rdRegister=0). Write-back therefore never repeats.
- busAck is sampled only in WAIT_ACK; an ack seen in IDLE is ignored.
- Latency:
  - Non-memory op: 1 cycle through MEM/WB.
  - Memory op with ack in the first WAIT_ACK cycle: 2 cycles, 1 of them stalled.
  - General memory op: 1 + (cycles until ack).
- Back-to-back accesses: after completion the next access starts from IDLE. One IDLE cycle with stall=1 always precedes each busReq.

Test Plan:
- Reset with all inputs at 0 -> every output 0, stall=0. Assert reset low while in WAIT_ACK -> busReq=0 immediately (asynchronous), no MEM/WB write.
- ALU op (memRead=0, memWrite=0, regWrite=1, rd=5, ALUin=0x1234) -> next edge: regWriteRegister=1, rdRegister=5, ALURegister=0x1234, stall never 1.
- Load, ALUin=0x100, busAck after 3 WAIT_ACK cycles with busRData=0xDEADBEEF -> busAddr=0x100, busWe=0, stall high 4 cycles, 4 bubbles in MEM/WB, then readDataRegister=0xDEADBEEF, regWriteRegister=1.
- Store, ALUin=0x204, writeDataIn=0xCAFE0001, busAck in the first WAIT_ACK cycle -> busWe=1, busWData=0xCAFE0001, stall high exactly 1 cycle, readDataRegister=0.
- Load, ALUin=0x102 -> no busReq, alignError=1, regWriteRegister=0, 1-cycle pass-through; alignError stays 1 across later ops.
- Load with busAck held 0, TIMEOUT_CYCLES=4 -> busReq high 4 cycles, then busError=1, regWriteRegister=0, stall=0. Rerun with busAck=1 on the 4th cycle -> normal completion, busError=0.
